// File: rtl/dec_pkg.sv
// Shared definitions for the register decoder / scanner.
//   mode_e  : 2-bit operating mode encodings (DIRECT, THERMO, SCAN, reserved)
//   state_e : scan controller state (IDLE, SCAN)
package dec_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell countdown used by the scanner.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load counter and latched dwell from dwell_in (wins over all)
//   clear     : force counter to 0 (latched dwell kept)
//   run       : count down; at 0 reload from the latched dwell
//   dwell_in  : dwell value sampled on start
//   expired   : run is active and the counter is at 0 this cycle
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell_in,
  output logic               expired
);

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] lat_q, lat_d;

  assign expired = run && (cnt_q == '0);

  // Next counter / latched-dwell values.
  always_comb begin
    cnt_d = cnt_q;
    lat_d = lat_q;
    if (start) begin
      cnt_d = dwell_in;
      lat_d = dwell_in;
    end else if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == '0) begin
        cnt_d = lat_q;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and latched-dwell registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lat_q <= lat_d;
    end
  end

endmodule

// File: rtl/reg_decoder_scan.sv
// Registered N-to-2**N decoder with one-hot, thermometer and scanning modes.
//   clk, rst : clock, synchronous active-high reset
//   en       : enable; low drives out/valid to 0 at the next edge
//   mode     : 00 one-hot, 01 thermometer, 10 scan, 11 reserved
//   in       : decode index, or scan start index
//   load     : starts/restarts a scan (en=1, mode=10)
//   dwell    : cycles-minus-one each scan position is held
//   out      : registered decoded vector
//   valid    : out carries a legal decode
//   step     : pulse when the scan index advances
//   wrap     : pulse when the scan index advances from 2**N-1 to 0
module reg_decoder_scan
  import dec_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [N-1:0]       in,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    out,
  output logic               valid,
  output logic               step,
  output logic               wrap
);

  localparam int          W       = 2**N;
  localparam logic [N-1:0] IDX_MAX = '1;
  localparam logic [N-1:0] IDX_ONE = N'(1);

  function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
    logic [W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] thermo(input logic [N-1:0] sel);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) begin
      v[i] = (N'(i) <= sel);
    end
    return v;
  endfunction

  state_e         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [W-1:0]   out_q, out_d;
  logic           valid_q, valid_d;
  logic           step_q, step_d;
  logic           wrap_q, wrap_d;
  logic           tmr_start, tmr_clear, tmr_run, tmr_expired;
  logic           scan_ok;
  logic [W-1:0]   plain_out;
  logic           plain_valid;

  assign scan_ok = en && (mode == MODE_SCAN);

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start),
    .clear    (tmr_clear),
    .run      (tmr_run),
    .dwell_in (dwell),
    .expired  (tmr_expired)
  );

  // Non-scan decode; SCAN mode outside an active scan decodes to nothing.
  always_comb begin
    plain_out   = '0;
    plain_valid = 1'b0;
    if (en) begin
      case (mode)
        MODE_DIRECT: begin
          plain_out   = onehot(in);
          plain_valid = 1'b1;
        end
        MODE_THERMO: begin
          plain_out   = thermo(in);
          plain_valid = 1'b1;
        end
        default: begin
          plain_out   = '0;
          plain_valid = 1'b0;
        end
      endcase
    end else begin
      plain_out   = '0;
      plain_valid = 1'b0;
    end
  end

  // Scan FSM next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_d     = plain_out;
    valid_d   = plain_valid;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    tmr_run   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scan_ok && load) begin
          state_d   = ST_SCAN;
          idx_d     = in;
          tmr_start = 1'b1;
          out_d     = onehot(in);
          valid_d   = 1'b1;
        end else begin
          idx_d = '0;
        end
      end
      ST_SCAN: begin
        if (!scan_ok) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          tmr_clear = 1'b1;
        end else if (load) begin
          // A restart suppresses any expiry that coincides with it.
          idx_d     = in;
          tmr_start = 1'b1;
          out_d     = onehot(in);
          valid_d   = 1'b1;
        end else begin
          tmr_run = 1'b1;
          valid_d = 1'b1;
          if (tmr_expired) begin
            idx_d  = idx_q + IDX_ONE;
            step_d = 1'b1;
            wrap_d = (idx_q == IDX_MAX);
            out_d  = onehot(idx_q + IDX_ONE);
          end else begin
            out_d = onehot(idx_q);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        idx_d     = '0;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign step  = step_q;
  assign wrap  = wrap_q;

endmodule

// File: doc/reg_decoder_scan.md
REG_DECODER_SCAN -- requirements
Module: reg_decoder_scan

Interface
REQ-001 Parameter N, default 3: select-input width; output width is 2**N; legal range 1..6.
REQ-002 Parameter DWELL_W, default 4: dwell-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  enable; low forces out to zero at next edge.
REQ-006 mode  input  2  00 DIRECT one-hot, 01 THERMO, 10 SCAN, 11 reserved.
REQ-007 in  input  N  select index (DIRECT/THERMO), start index (SCAN).
REQ-008 load  input  1  single-cycle pulse; starts/restarts a scan.
REQ-009 dwell  input  DWELL_W  cycles-minus-one each scan position is held.
REQ-010 out  output  2**N  registered decoded vector.
REQ-011 valid  output  1  registered; high when out carries a legal-mode decode.
REQ-012 step  output  1  one-cycle pulse on the cycle the scan index advances.
REQ-013 wrap  output  1  one-cycle pulse when the scan index advances from 2**N-1 to 0.

Function
REQ-014 All outputs SHALL be registered; latency from in/mode/en to out SHALL be exactly 1 cycle in DIRECT and THERMO.
REQ-015 DIRECT: out SHALL equal one-hot bit in, all others 0, when en=1.
REQ-016 THERMO: out bits 0..in SHALL be 1, bits above in 0, when en=1 (in=0 -> out=...0001).
REQ-017 Reserved mode or en=0: out SHALL be 0 and valid 0 at next edge; valid SHALL be 1 otherwise.
REQ-018 FSM states IDLE and SCAN; IDLE -> SCAN on load=1 with en=1 and mode=10; SCAN -> IDLE when en=0 or mode!=10.
REQ-019 On SCAN entry: index <= in, dwell counter <= dwell (latched), out <= one-hot(in) on the next edge.
REQ-020 In SCAN, the counter SHALL decrement each cycle; on reaching 0 it reloads the latched dwell, index increments modulo 2**N, step pulses.
REQ-021 Each scan position SHALL be held for exactly latched dwell+1 cycles; dwell=0 advances every cycle.
REQ-022 wrap SHALL pulse coincident with step on the 2**N-1 -> 0 transition only.
REQ-023 load during SCAN SHALL restart from current in and dwell; load wins over a simultaneous counter expiry (no step, no wrap that cycle).
REQ-024 dwell changes during SCAN SHALL have no effect until the next load.
REQ-025 Leaving SCAN SHALL clear index and counter to 0; out follows the new mode one cycle later.
REQ-026 In IDLE with mode=10, out SHALL be 0 and valid 0 until load.
REQ-027 step and wrap SHALL be 0 outside SCAN.

Reset
REQ-028 rst=1 SHALL, at the next edge, set out=0, valid=0, step=0, wrap=0, state=IDLE, index=0, counter=0, latched dwell=0.
REQ-029 rst SHALL override en, load and all modes, including mid-scan; first decode SHALL appear 1 cycle after the first edge with rst=0.

Structure
REQ-030 Shared package dec_pkg SHALL hold mode encodings (MODE_DIRECT, MODE_THERMO, MODE_SCAN, MODE_RSVD) and the FSM state type.
REQ-031 The dwell countdown with reload and expiry flag SHALL be a sub-module dwell_timer, parametrised by DWELL_W.

Verification (N=3, DWELL_W=4)
REQ-032 rst high 2 cycles, en=1 mode=00 in=5 -> out=0 during rst; 1 cycle after release out=8'b0010_0000, valid=1.
REQ-033 mode=01, in=0 then 3 then 7 -> out 8'h01, 8'h0F, 8'hFF, each 1 cycle later.
REQ-034 mode=10, dwell=2, in=6, load pulse -> out 8'h40 for 3 cycles, 8'h80 for 3, then 8'h01 with step and wrap high on that cycle.
REQ-035 mode=10, dwell=0, in=0, load -> out walks 01,02,04,...,80,01 one per cycle; step high every advance, wrap once per 8.
REQ-036 Mid-scan load with in=2 on the expiry cycle -> out=8'h04 next cycle, step=0, wrap=0; en=0 mid-scan -> out=0, valid=0 next cycle.
REQ-037 mode=11 or rst asserted mid-scan -> out=0, valid=0, step=0 at next edge; rescan requires a new load.
